// File: rtl/seq_pkg.sv
// Shared types for the drum step sequencer: transport state encoding and its width.
package seq_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_tick_div.sv
// Step-period divider: counts div_q 0..period_q and strobes tc at the terminal count.
// period_q is reloaded from period_i on load and at every terminal-count wrap.
module seq_tick_div #(
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic              hold,
    input  logic [TICK_W-1:0] period_i,
    output logic              tc
);

    logic [TICK_W-1:0] div_q;
    logic [TICK_W-1:0] period_q;

    // Raw compare; the caller qualifies it with hold so a paused counter parked at
    // period_q does not advance the step.
    assign tc = (div_q == period_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q    <= '0;
            period_q <= '0;
        end else if (clear) begin
            div_q <= '0;
            if (load) period_q <= period_i;
        end else if (!hold) begin
            if (tc) begin
                div_q    <= '0;
                period_q <= period_i;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Drum step sequencer: TRACKS x STEPS pattern, transport FSM, step counter and
// registered one-cycle trigger outputs driven by the seq_tick_div step clock.
module step_sequencer
    import seq_pkg::*;
#(
    parameter int TRACKS = 4,
    parameter int STEPS  = 16,
    parameter int STEP_W = 4,
    parameter int TRK_W  = 2,
    parameter int TICK_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               play_i,
    input  logic               pause_i,
    input  logic               stop_i,
    input  logic [TICK_W-1:0]  period_i,
    input  logic               pat_wr_i,
    input  logic [TRK_W-1:0]   pat_trk_i,
    input  logic [STEP_W-1:0]  pat_step_i,
    input  logic               pat_val_i,
    output logic [TRACKS-1:0]  trig_o,
    output logic [STEP_W-1:0]  step_o,
    output logic               step_tick_o,
    output logic               bar_o,
    output logic [STATE_W-1:0] state_o
);

    localparam logic [TRK_W:0]    TRK_LIM  = (TRK_W + 1)'(TRACKS);
    localparam logic [STEP_W:0]   STEP_LIM = (STEP_W + 1)'(STEPS);
    localparam logic [STEP_W-1:0] STEP_TOP = STEP_W'(STEPS - 1);

    seq_state_e                      state_q, state_d;
    logic [STEP_W-1:0]               step_q, step_d, ev_step;
    logic [TRACKS-1:0][STEPS-1:0]    pat_q;
    logic [TRACKS-1:0]               trig_d;
    logic                            tc, div_hold, div_clr, div_load, fire;
    logic                            wr_ok;

    seq_tick_div #(.TICK_W(TICK_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .clear    (div_clr),
        .load     (div_load),
        .hold     (div_hold),
        .period_i (period_i),
        .tc       (tc)
    );

    // Transport FSM; stop beats pause beats play within a cycle.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        ev_step  = step_q;
        div_hold = 1'b1;
        div_clr  = 1'b0;
        div_load = 1'b0;
        fire     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop_i && !pause_i && play_i) begin
                    state_d  = ST_RUN;
                    step_d   = '0;
                    ev_step  = '0;
                    div_clr  = 1'b1;
                    div_load = 1'b1;
                    fire     = 1'b1;
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    div_clr = 1'b1;
                end else if (pause_i) begin
                    state_d = ST_PAUSE;
                end else begin
                    div_hold = 1'b0;
                    if (tc) begin
                        step_d  = (step_q == STEP_TOP) ? '0 : step_q + 1'b1;
                        ev_step = step_d;
                        fire    = 1'b1;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_i) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    div_clr = 1'b1;
                end else if (!pause_i && play_i) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
                div_clr = 1'b1;
            end
        endcase
    end

    // Event reads the pattern as registered, so a same-cycle write is not seen.
    for (genvar t = 0; t < TRACKS; t++) begin : g_trk
        assign trig_d[t] = pat_q[t][ev_step];
    end

    assign wr_ok = pat_wr_i && ({1'b0, pat_trk_i} < TRK_LIM) && ({1'b0, pat_step_i} < STEP_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            trig_o      <= '0;
            step_tick_o <= 1'b0;
            bar_o       <= 1'b0;
            pat_q       <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            step_tick_o <= fire;
            bar_o       <= fire && (ev_step == '0);
            trig_o      <= fire ? trig_d : '0;
            if (wr_ok) pat_q[pat_trk_i][pat_step_i] <= pat_val_i;
        end
    end

    assign step_o  = step_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: a transport/tempo model predicts every cycle's
// status and every step event; a posedge monitor pops and compares.
module tb_step_sequencer;

    localparam int TRACKS = 4;
    localparam int STEPS  = 16;
    localparam int STEP_W = 4;
    localparam int TRK_W  = 2;
    localparam int TICK_W = 24;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               play_i = 1'b0, pause_i = 1'b0, stop_i = 1'b0;
    logic [TICK_W-1:0]  period_i = '0;
    logic               pat_wr_i = 1'b0;
    logic [TRK_W-1:0]   pat_trk_i = '0;
    logic [STEP_W-1:0]  pat_step_i = '0;
    logic               pat_val_i = 1'b0;
    logic [TRACKS-1:0]  trig_o;
    logic [STEP_W-1:0]  step_o;
    logic               step_tick_o, bar_o;
    logic [1:0]         state_o;

    step_sequencer #(.TRACKS(TRACKS), .STEPS(STEPS), .STEP_W(STEP_W), .TRK_W(TRK_W),
                     .TICK_W(TICK_W)) dut (
        .clk(clk), .rst(rst), .play_i(play_i), .pause_i(pause_i), .stop_i(stop_i),
        .period_i(period_i), .pat_wr_i(pat_wr_i), .pat_trk_i(pat_trk_i),
        .pat_step_i(pat_step_i), .pat_val_i(pat_val_i), .trig_o(trig_o), .step_o(step_o),
        .step_tick_o(step_tick_o), .bar_o(bar_o), .state_o(state_o)
    );

    always #5 clk = ~clk;

    typedef struct { int tag; int step; logic [TRACKS-1:0] trig; logic bar; } ev_t;
    typedef struct { int tag; int state; int step; logic tick; } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  cyc = 0;
    int  n_chk = 0, n_fail = 0;

    // Reference model: transport mode, current step, cycles already spent in it.
    int  m_state = 0, m_step = 0, m_el = 0, m_per = 0;
    bit  m_fired = 0;
    bit  pat [TRACKS][STEPS];

    task automatic chk(input string nm, input bit ok, input string det);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: %s", nm, det);
        end
    endtask

    // Predict the outcome of the inputs currently driven, then advance one cycle.
    task automatic cyc_step();
        ev_t e;
        st_t s;
        m_fired = 0;
        if (rst) begin
            m_state = 0; m_step = 0; m_el = 0; m_per = 0;
            foreach (pat[t, k]) pat[t][k] = 0;
        end else begin
            case (m_state)
                0: if (!stop_i && !pause_i && play_i) begin
                       m_state = 1; m_step = 0; m_el = 0; m_per = int'(period_i); m_fired = 1;
                   end
                1: if (stop_i) begin
                       m_state = 0; m_step = 0; m_el = 0;
                   end else if (pause_i) begin
                       m_state = 2;
                   end else if (m_el == m_per) begin
                       m_step = (m_step + 1) % STEPS; m_el = 0; m_per = int'(period_i); m_fired = 1;
                   end else begin
                       m_el++;
                   end
                default: if (stop_i) begin
                       m_state = 0; m_step = 0; m_el = 0;
                   end else if (!pause_i && play_i) begin
                       m_state = 1;
                   end
            endcase
            if (m_fired) begin
                e.tag = cyc + 1; e.step = m_step; e.bar = (m_step == 0);
                for (int t = 0; t < TRACKS; t++) e.trig[t] = pat[t][m_step];
                ev_q.push_back(e);
            end
            if (pat_wr_i && int'(pat_trk_i) < TRACKS && int'(pat_step_i) < STEPS)
                pat[pat_trk_i][pat_step_i] = pat_val_i;
        end
        s.tag = cyc + 1; s.state = m_state; s.step = m_step; s.tick = m_fired;
        st_q.push_back(s);
        @(negedge clk);
        rst = 0; play_i = 0; pause_i = 0; stop_i = 0; pat_wr_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_step();
    endtask

    task automatic wr(input int t, input int k, input bit v);
        pat_wr_i = 1; pat_trk_i = TRK_W'(t); pat_step_i = STEP_W'(k); pat_val_i = v;
        cyc_step();
    endtask

    // Monitor: status every cycle, event contents whenever the DUT ticks.
    initial begin
        st_t s;
        ev_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (st_q.size() != 0) begin
                s = st_q.pop_front();
                chk("status", s.tag == cyc && int'(state_o) == s.state && int'(step_o) == s.step
                    && step_tick_o == s.tick,
                    $sformatf("cyc %0d got state=%0d step=%0d tick=%0b, want tag=%0d state=%0d step=%0d tick=%0b",
                              cyc, state_o, step_o, step_tick_o, s.tag, s.state, s.step, s.tick));
                if (step_tick_o) begin
                    if (ev_q.size() == 0) begin
                        chk("event", 0, $sformatf("cyc %0d got unexpected tick step=%0d", cyc, step_o));
                    end else begin
                        e = ev_q.pop_front();
                        chk("event", e.tag == cyc && int'(step_o) == e.step && trig_o == e.trig
                            && bar_o == e.bar,
                            $sformatf("cyc %0d got step=%0d trig=%b bar=%0b, want cyc %0d step=%0d trig=%b bar=%0b",
                                      cyc, step_o, trig_o, bar_o, e.tag, e.step, e.trig, e.bar));
                    end
                end else begin
                    chk("quiet", trig_o == '0 && bar_o == 1'b0,
                        $sformatf("cyc %0d got trig=%b bar=%0b without tick, want 0", cyc, trig_o, bar_o));
                end
            end
        end
    end

    initial begin
        bit seen5;
        @(negedge clk);
        rst = 1; cyc_step();
        rst = 1; cyc_step();
        idle(6);

        // Tempo and wrap: 4-cycle steps, full bar plus wrap.
        period_i = 3;
        play_i = 1; cyc_step();
        idle(70);
        stop_i = 1; cyc_step();
        idle(2);

        // Pattern on track 2 every fourth step.
        for (int k = 0; k < STEPS; k += 4) wr(2, k, 1);
        play_i = 1; cyc_step();
        idle(66);

        // Pause two cycles after the step-5 tick, hold, resume.
        stop_i = 1; cyc_step();
        play_i = 1; cyc_step();
        seen5 = 0;
        for (int i = 0; i < 200 && !seen5; i++) begin
            cyc_step();
            seen5 = m_fired && m_step == 5;
        end
        chk("reach_step5", seen5, $sformatf("step-5 event got %0b, want 1", seen5));
        idle(1);
        pause_i = 1; cyc_step();
        play_i = 1; pause_i = 1; cyc_step();
        idle(19);
        play_i = 1; cyc_step();
        idle(12);

        // All three commands together in RUN.
        play_i = 1; pause_i = 1; stop_i = 1; cyc_step();
        idle(3);
        stop_i = 1; cyc_step();

        // Period change mid-step.
        play_i = 1; cyc_step();
        idle(1);
        period_i = 0;
        idle(20);

        // Write collision against the event firing the same cycle.
        while (((m_step + 1) % STEPS) != 4) cyc_step();
        wr(2, 4, 0);
        idle(20);

        // Reset mid-run, then a bar over the cleared pattern.
        rst = 1; cyc_step();
        idle(2);
        period_i = 1;
        play_i = 1; cyc_step();
        idle(36);

        // Random traffic.
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            play_i  = (r < 6);
            pause_i = (r >= 6 && r < 9);
            stop_i  = (r == 9);
            rst     = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 15) == 0) period_i = TICK_W'($urandom_range(0, 5));
            if ($urandom_range(0, 3) == 0) begin
                pat_wr_i   = 1;
                pat_trk_i  = TRK_W'($urandom_range(0, TRACKS - 1));
                pat_step_i = STEP_W'($urandom_range(0, STEPS - 1));
                pat_val_i  = 1'($urandom_range(0, 1));
            end
            cyc_step();
        end

        @(posedge clk);
        #5;
        chk("drain", ev_q.size() == 0 && st_q.size() == 0,
            $sformatf("left events=%0d status=%0d, want 0 and 0", ev_q.size(), st_q.size()));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
